// File: rtl/mem_wb_pkg.sv
// Shared constants for the MEM/WB pipeline register: write-back source
// encodings and RISC-V load funct3 codes.
package mem_wb_pkg;

  localparam int unsigned WB_SEL_BITWIDTH = 2;
  localparam int unsigned FUNCT3_BITWIDTH = 3;

  localparam logic [WB_SEL_BITWIDTH-1:0] WB_SEL_ALU = 2'b00;
  localparam logic [WB_SEL_BITWIDTH-1:0] WB_SEL_MEM = 2'b01;
  localparam logic [WB_SEL_BITWIDTH-1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [FUNCT3_BITWIDTH-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_BITWIDTH-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_BITWIDTH-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_BITWIDTH-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: picks the addressed byte/half from the
// low 32 bits of the read word and sign- or zero-extends it to the word width.
module load_align
  import mem_wb_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = 32
) (
  input  logic [FUNCT3_BITWIDTH-1:0] funct3_i,
  input  logic [1:0]                 addr_low_i,
  input  logic [WORD_BITWIDTH-1:0]   rdata_i,
  output logic [WORD_BITWIDTH-1:0]   aligned_c
);

  localparam int unsigned BYTE_PAD = WORD_BITWIDTH - 8;
  localparam int unsigned HALF_PAD = WORD_BITWIDTH - 16;

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[7:0];
    case (addr_low_i)
      2'd1:    byte_c = rdata_i[15:8];
      2'd2:    byte_c = rdata_i[23:16];
      2'd3:    byte_c = rdata_i[31:24];
      default: byte_c = rdata_i[7:0];
    endcase
    half_c = addr_low_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    aligned_c = rdata_i;
    case (funct3_i)
      F3_LB:   aligned_c = {{BYTE_PAD{byte_c[7]}}, byte_c};
      F3_LBU:  aligned_c = {{BYTE_PAD{1'b0}}, byte_c};
      F3_LH:   aligned_c = {{HALF_PAD{half_c[15]}}, half_c};
      F3_LHU:  aligned_c = {{HALF_PAD{1'b0}}, half_c};
      default: aligned_c = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with write-back mux, x0 write suppression and a
// retire counter. Define MEM_WB_LOAD_ALIGN_EN to align sub-word load data.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH    = 32,
  parameter int unsigned REG_NUM_BITWIDTH = 5,
  parameter int unsigned CNT_BITWIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic                        in_regWrite,
  input  logic [WB_SEL_BITWIDTH-1:0]  in_wbSel,
  input  logic [FUNCT3_BITWIDTH-1:0]  in_loadFunct3,
  input  logic [1:0]                  in_addrLow,
  input  logic [WORD_BITWIDTH-1:0]    in_ALUresult,
  input  logic [WORD_BITWIDTH-1:0]    in_memReadData,
  input  logic [WORD_BITWIDTH-1:0]    in_pcPlus4,
  input  logic [REG_NUM_BITWIDTH-1:0] in_regToWrite,
  output logic                        wb_valid,
  output logic                        wb_regWrite,
  output logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
  output logic [WORD_BITWIDTH-1:0]    wb_regWriteData,
  output logic [CNT_BITWIDTH-1:0]     wb_retireCount
);

  logic [WORD_BITWIDTH-1:0] mem_src_c;

`ifdef MEM_WB_LOAD_ALIGN_EN
  load_align #(
    .WORD_BITWIDTH (WORD_BITWIDTH)
  ) u_load_align (
    .funct3_i   (in_loadFunct3),
    .addr_low_i (in_addrLow),
    .rdata_i    (in_memReadData),
    .aligned_c  (mem_src_c)
  );
`else
  logic unused_align_inputs;
  assign unused_align_inputs = ^{in_loadFunct3, in_addrLow};
  assign mem_src_c = in_memReadData;
`endif

  logic                        valid_q,     valid_d;
  logic                        reg_write_q, reg_write_d;
  logic [REG_NUM_BITWIDTH-1:0] rd_q,        rd_d;
  logic [WORD_BITWIDTH-1:0]    data_q,      data_d;
  logic [CNT_BITWIDTH-1:0]     cnt_q,       cnt_d;

  // Next-state values for a normal load; stall/flush/reset are applied in the register.
  always_comb begin
    valid_d     = in_valid;
    reg_write_d = in_valid & in_regWrite & (in_regToWrite != '0);
    rd_d        = in_regToWrite;
    cnt_d       = in_valid ? cnt_q + CNT_BITWIDTH'(1) : cnt_q;
    case (in_wbSel)
      WB_SEL_MEM: data_d = mem_src_c;
      WB_SEL_PC4: data_d = in_pcPlus4;
      default:    data_d = in_ALUresult;
    endcase
  end

  // Priority rst > flush > stall > load; flush keeps the retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else if (!stall) begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb_valid        = valid_q;
  assign wb_regWrite     = reg_write_q;
  assign wb_regToWrite   = rd_q;
  assign wb_regWriteData = data_q;
  assign wb_retireCount  = cnt_q;

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32: datapath word width, any multiple of 16 and at least 32.
REQ-002 SHALL have parameter REG_NUM_BITWIDTH, default 5: register index width.
REQ-003 SHALL have parameter CNT_BITWIDTH, default 32: retire counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port stall, input, 1: hold all registers.
REQ-007 SHALL have port flush, input, 1: load a bubble.
REQ-008 SHALL have port in_valid, input, 1: the MEM-stage instruction is real.
REQ-009 SHALL have port in_regWrite, input, 1: the instruction writes rd.
REQ-010 SHALL have port in_wbSel, input, 2: write-back source; 00 ALU, 01 memory, 10 PC+4, 11 treated as ALU.
REQ-011 SHALL have port in_loadFunct3, input, 3: load type.
REQ-012 SHALL have port in_addrLow, input, 2: byte offset of the load address.
REQ-013 SHALL have ports in_ALUresult, in_memReadData and in_pcPlus4, input, WORD_BITWIDTH each.
REQ-014 SHALL have port in_regToWrite, input, REG_NUM_BITWIDTH: rd.
REQ-015 SHALL have outputs wb_valid (1), wb_regWrite (1), wb_regToWrite (REG_NUM_BITWIDTH), wb_regWriteData (WORD_BITWIDTH) and wb_retireCount (CNT_BITWIDTH), all registered.

Function
REQ-016 SHALL update on each clk edge with priority rst > flush > stall > load.
REQ-017 SHALL, on load, register the selected write-back data, rd, and valid; the outputs appear one cycle after the inputs.
REQ-018 SHALL, on flush, set wb_valid=0, wb_regWrite=0, wb_regToWrite=0 and wb_regWriteData=0 in the next cycle; flush overrides a simultaneous stall.
REQ-019 SHALL, on stall without flush, hold every output, including the counter, unchanged.
REQ-020 SHALL set the registered wb_regWrite to in_valid AND in_regWrite AND (in_regToWrite != 0); writes to x0 are suppressed.
REQ-021 SHALL register wb_regToWrite unchanged, even when the write is suppressed.
REQ-022 SHALL form the memory source as the load-aligned value of in_memReadData (REQ-030).
REQ-023 SHALL increment wb_retireCount by 1 on each load cycle with in_valid=1, wrapping modulo 2^CNT_BITWIDTH.
REQ-024 SHALL NOT increment wb_retireCount on flush or stall cycles.
REQ-025 SHALL NOT reset wb_retireCount on flush; only rst clears it.

Reset
REQ-026 SHALL, while rst is high at a clk edge, drive all outputs to 0 in the next cycle, regardless of stall and flush.
REQ-027 SHALL, on reset mid-stall, discard the held state; the first edge after rst falls behaves as a normal load.

Configuration
REQ-028 SHALL use macro MEM_WB_LOAD_ALIGN_EN to select load alignment.
REQ-029 SHALL, without MEM_WB_LOAD_ALIGN_EN, use the memory source in_memReadData unmodified; in_loadFunct3 and in_addrLow are ignored.
REQ-030 SHALL, with MEM_WB_LOAD_ALIGN_EN, extract from in_memReadData[31:0] as follows:
- 000 LB: byte at in_addrLow, sign-extended.
- 100 LBU: byte at in_addrLow, zero-extended.
- 001 LH: half at in_addrLow[1], sign-extended; in_addrLow[0] ignored.
- 101 LHU: half at in_addrLow[1], zero-extended.
- others: the full word.
Extension is to WORD_BITWIDTH.

Structure
REQ-031 SHALL take the wbSel encodings (WB_SEL_ALU, WB_SEL_MEM, WB_SEL_PC4) and the load funct3 constants from the shared package mem_wb_pkg.
REQ-032 SHALL place the alignment logic in the combinational sub-module load_align, instantiated only under MEM_WB_LOAD_ALIGN_EN.

Verification
REQ-033 SHALL check: rst=1 for 2 cycles with stall=1 -> all outputs 0.
REQ-034 SHALL check: in_valid=1, in_regWrite=1, wbSel=00, ALU=0x1234, rd=5 -> next cycle wb_regWriteData=0x1234, wb_regWrite=1, wb_regToWrite=5, wb_retireCount=1.
REQ-035 SHALL check: rd=0, regWrite=1, valid=1 -> wb_regWrite=0 and the counter increments.
REQ-036 SHALL check: stall=1 for 3 cycles while the inputs change -> outputs frozen; then flush=1 with stall=1 -> wb_valid=0, wb_regWrite=0, and the counter unchanged.
REQ-037 SHALL check, with ALIGN_EN, mem=0x80F0_7F01:
- LB addrLow=3 -> 0xFFFF_FF80.
- LBU addrLow=2 -> 0x0000_00F0.
- LH addrLow=2 -> 0xFFFF_80F0.
- LW -> 0x80F0_7F01.
REQ-038 SHALL check: wbSel=10, pcPlus4=0x0000_0104 -> wb_regWriteData=0x104; and counter preset to all-ones by 2^32-1 retires -> next retire gives 0.
